// File: rtl/ntsc_timing_ctrl.sv
// ntsc_timing_ctrl
// Raster sequencer for the NTSC composite path. It counts pixel ticks per line
// and lines per field. From those counts it produces composite sync, blanking,
// the colour-burst gate, the active-video window and the active pixel
// coordinates that drive the RGB2CVBS encoder and the upstream pixel fetch.
//
// Ports:
//   clk         system clock (50 MHz)
//   rst         asynchronous reset, active-low
//   en          run enable; low forces the idle/reset raster state
//   tick        one-clk pixel tick (1 in every 4 clk)
//   sync_n      composite sync, active-low
//   blank       high outside the active window
//   burst       colour-burst gate
//   active      high inside the active window
//   x, y        active pixel column / line, 0 when inactive
//   line_start  one-clk pulse when the pixel counter wraps to 0
//   field_start one-clk pulse when the line counter wraps to 0
//   field       field parity
//
// Optional feature: define NTSC_INTERLACE_EN to alternate fields of V_TOTAL
// and V_TOTAL+1 lines, with field toggling at each field wrap. Without it
// every field is V_TOTAL lines and field is tied to 0.

module ntsc_timing_ctrl #(
  parameter int H_TOTAL        = 794,
  parameter int H_SYNC         = 59,
  parameter int BURST_START    = 66,
  parameter int BURST_LEN      = 31,
  parameter int H_ACTIVE_START = 134,
  parameter int H_ACTIVE       = 640,
  parameter int V_TOTAL        = 262,
  parameter int V_SYNC_START   = 3,
  parameter int V_SYNC_LEN     = 3,
  parameter int V_ACTIVE_START = 21,
  parameter int V_ACTIVE       = 240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       tick,
  output logic       sync_n,
  output logic       blank,
  output logic       burst,
  output logic       active,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       line_start,
  output logic       field_start,
  output logic       field
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END   = 10'(H_SYNC);
  localparam logic [9:0] H_BROAD_END  = 10'(H_TOTAL - H_SYNC);
  localparam logic [9:0] BURST_LO     = 10'(BURST_START);
  localparam logic [9:0] BURST_HI     = 10'(BURST_START + BURST_LEN);
  localparam logic [9:0] HA_LO        = 10'(H_ACTIVE_START);
  localparam logic [9:0] HA_HI        = 10'(H_ACTIVE_START + H_ACTIVE);
  localparam logic [8:0] V_LAST_SHORT = 9'(V_TOTAL - 1);
  localparam logic [8:0] VS_LO        = 9'(V_SYNC_START);
  localparam logic [8:0] VS_HI        = 9'(V_SYNC_START + V_SYNC_LEN);
  localparam logic [8:0] VA_LO        = 9'(V_ACTIVE_START);
  localparam logic [8:0] VA_HI        = 9'(V_ACTIVE_START + V_ACTIVE);

  state_t     state_q, state_d;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [8:0] v_cnt_q, v_cnt_d;
  logic       sync_n_q, sync_n_d;
  logic       blank_q, blank_d;
  logic       burst_q, burst_d;
  logic       active_q, active_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       line_start_q, line_start_d;
  logic       field_start_q, field_start_d;
  logic [8:0] v_last;
  logic       vsync_line;
  logic       active_line;
  logic       in_active;

`ifdef NTSC_INTERLACE_EN
  localparam logic [8:0] V_LAST_LONG = 9'(V_TOTAL);
  logic field_q, field_d;

  // The odd field carries one extra line, so its wrap point is one later.
  assign v_last = field_q ? V_LAST_LONG : V_LAST_SHORT;
  assign field  = field_q;
`else
  assign v_last = V_LAST_SHORT;
  assign field  = 1'b0;
`endif

  // Next-state, counter advance and output decode. Outputs are decoded from
  // the next counter values so they move on the same edge as the counters.
  // In the first RUN clk the counters sit at 0,0 with reset-valued outputs;
  // nothing is decoded until the first tick moves the raster.
  always_comb begin
    state_d       = state_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    sync_n_d      = sync_n_q;
    blank_d       = blank_q;
    burst_d       = burst_q;
    active_d      = active_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    field_start_d = 1'b0;
`ifdef NTSC_INTERLACE_EN
    field_d       = field_q;
`endif
    vsync_line    = 1'b0;
    active_line   = 1'b0;
    in_active     = 1'b0;

    if (!en) begin
      state_d  = IDLE;
      h_cnt_d  = '0;
      v_cnt_d  = '0;
      sync_n_d = 1'b1;
      blank_d  = 1'b1;
      burst_d  = 1'b0;
      active_d = 1'b0;
      x_d      = '0;
      y_d      = '0;
`ifdef NTSC_INTERLACE_EN
      field_d  = 1'b0;
`endif
    end else if (state_q == IDLE) begin
      state_d = RUN;
    end else if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d      = '0;
        line_start_d = 1'b1;
        if (v_cnt_q == v_last) begin
          v_cnt_d       = '0;
          field_start_d = 1'b1;
`ifdef NTSC_INTERLACE_EN
          field_d       = ~field_q;
`endif
        end else begin
          v_cnt_d = v_cnt_q + 9'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end

      vsync_line  = (v_cnt_d >= VS_LO) && (v_cnt_d < VS_HI);
      active_line = (v_cnt_d >= VA_LO) && (v_cnt_d < VA_HI);
      in_active   = active_line && (h_cnt_d >= HA_LO) && (h_cnt_d < HA_HI);

      // Vertical sync lines use a broad pulse that is low for most of the line.
      sync_n_d = vsync_line ? (h_cnt_d >= H_BROAD_END) : (h_cnt_d >= H_SYNC_END);
      burst_d  = !vsync_line && (h_cnt_d >= BURST_LO) && (h_cnt_d < BURST_HI);
      active_d = in_active;
      blank_d  = !in_active;
      x_d      = in_active ? (h_cnt_d - HA_LO) : '0;
      y_d      = in_active ? (v_cnt_d - VA_LO) : '0;
    end
  end

  // State, counter and registered-output flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      sync_n_q      <= 1'b1;
      blank_q       <= 1'b1;
      burst_q       <= 1'b0;
      active_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      field_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      sync_n_q      <= sync_n_d;
      blank_q       <= blank_d;
      burst_q       <= burst_d;
      active_q      <= active_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      field_start_q <= field_start_d;
    end
  end

`ifdef NTSC_INTERLACE_EN
  // Field parity flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      field_q <= 1'b0;
    end else begin
      field_q <= field_d;
    end
  end
`endif

  assign sync_n      = sync_n_q;
  assign blank       = blank_q;
  assign burst       = burst_q;
  assign active      = active_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign field_start = field_start_q;

endmodule

// File: tb/tb_ntsc_timing_ctrl.sv
// tb_ntsc_timing_ctrl
// Bench for ntsc_timing_ctrl. Two instances share one stimulus stream: dut_a
// uses the full NTSC geometry, while dut_b keeps the horizontal timing but has
// a short field, so that field wraps and the bottom of the active window are
// reached within a short run. A raster model, based on tick counts, predicts
// every output of both instances on every clk. Directed checks pin a set of
// hand-computed points.

module tb_ntsc_timing_ctrl;

  localparam int H_TOTAL        = 794;
  localparam int H_SYNC         = 59;
  localparam int BURST_START    = 66;
  localparam int BURST_LEN      = 31;
  localparam int H_ACTIVE_START = 134;
  localparam int H_ACTIVE       = 640;

`ifdef NTSC_INTERLACE_EN
  localparam bit INTERLACE = 1'b1;
`else
  localparam bit INTERLACE = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic en   = 1'b0;
  logic tick = 1'b0;

  logic       sync_n_a, blank_a, burst_a, active_a, line_start_a, field_start_a, field_a;
  logic [9:0] x_a;
  logic [8:0] y_a;
  logic       sync_n_b, blank_b, burst_b, active_b, line_start_b, field_start_b, field_b;
  logic [9:0] x_b;
  logic [8:0] y_b;

  int compared   = 0;
  int mismatched = 0;

  // Model state: ticks counted since the raster left IDLE, and whether the
  // most recent clk edge was a counting tick.
  int m_n   = 0;
  bit m_run = 1'b0;
  bit m_adv = 1'b0;

  ntsc_timing_ctrl dut_a (
    .clk(clk), .rst(rst), .en(en), .tick(tick),
    .sync_n(sync_n_a), .blank(blank_a), .burst(burst_a), .active(active_a),
    .x(x_a), .y(y_a), .line_start(line_start_a), .field_start(field_start_a),
    .field(field_a)
  );

  ntsc_timing_ctrl #(
    .V_TOTAL(12), .V_SYNC_START(1), .V_SYNC_LEN(2), .V_ACTIVE_START(4), .V_ACTIVE(6)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .tick(tick),
    .sync_n(sync_n_b), .blank(blank_b), .burst(burst_b), .active(active_b),
    .x(x_b), .y(y_b), .line_start(line_start_b), .field_start(field_start_b),
    .field(field_b)
  );

  // 50 MHz system clock.
  initial forever #10 clk = ~clk;

  // Expected outputs {sync_n, blank, burst, active, x, y, line_start,
  // field_start, field} after n ticks, from the raster rules.
  function automatic logic [25:0] model_out(int n, bit adv, int vt, int vss, int vsl,
                                            int vas, int va);
    int h;
    int ln;
    int v;
    bit f;
    bit vs;
    bit s;
    bit b;
    bit a;
    bit ls;
    bit fs;
    logic [9:0] xv;
    logic [8:0] yv;
    if (n == 0) return {1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0, 1'b0};
    h  = n % H_TOTAL;
    ln = n / H_TOTAL;
    if (INTERLACE) begin
      ln = ln % (2 * vt + 1);
      f  = (ln >= vt);
      v  = f ? ln - vt : ln;
    end else begin
      f = 1'b0;
      v = ln % vt;
    end
    vs = (v >= vss) && (v < vss + vsl);
    s  = vs ? (h >= H_TOTAL - H_SYNC) : (h >= H_SYNC);
    b  = !vs && (h >= BURST_START) && (h < BURST_START + BURST_LEN);
    a  = (v >= vas) && (v < vas + va) && (h >= H_ACTIVE_START) &&
         (h < H_ACTIVE_START + H_ACTIVE);
    xv = a ? 10'(h - H_ACTIVE_START) : 10'd0;
    yv = a ? 9'(v - vas) : 9'd0;
    ls = adv && (h == 0);
    fs = ls && (v == 0);
    return {s, !a, b, a, xv, yv, ls, fs, f};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h (model tick %0d)", name, $time, act, exp, m_n);
    end
  endtask

  // Model update, using the same inputs the DUT sees at each rising edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run = 1'b0;
      m_n   = 0;
      m_adv = 1'b0;
    end else if (!en) begin
      m_run = 1'b0;
      m_n   = 0;
      m_adv = 1'b0;
    end else if (!m_run) begin
      m_run = 1'b1;
      m_adv = 1'b0;
    end else if (tick) begin
      m_n   = m_n + 1;
      m_adv = 1'b1;
    end else begin
      m_adv = 1'b0;
    end
  end

  // Every-cycle comparison of both instances against the model, sampled
  // mid-cycle.
  always @(negedge clk) begin
    check_output("raster_a",
      {6'd0, sync_n_a, blank_a, burst_a, active_a, x_a, y_a, line_start_a, field_start_a, field_a},
      {6'd0, model_out(m_n, m_adv, 262, 3, 3, 21, 240)});
    check_output("raster_b",
      {6'd0, sync_n_b, blank_b, burst_b, active_b, x_b, y_b, line_start_b, field_start_b, field_b},
      {6'd0, model_out(m_n, m_adv, 12, 1, 2, 4, 6)});
  end

  // One clk with the given tick value; returns 1 time unit after the edge.
  task automatic clock_cycle(input bit t);
    tick = t;
    @(posedge clk);
    #1;
  endtask

  // k pixel ticks, one tick every per clk.
  task automatic apply_stimulus(input int k, input int per);
    for (int i = 0; i < k; i++) begin
      for (int j = 0; j < per - 1; j++) clock_cycle(1'b0);
      clock_cycle(1'b1);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_sync_n"}, 32'(sync_n_a), 32'd1);
    check_output({tag, "_blank"}, 32'(blank_a), 32'd1);
    check_output({tag, "_burst"}, 32'(burst_a), 32'd0);
    check_output({tag, "_active"}, 32'(active_a), 32'd0);
    check_output({tag, "_x"}, 32'(x_a), 32'd0);
    check_output({tag, "_y"}, 32'(y_a), 32'd0);
    check_output({tag, "_line_start"}, 32'(line_start_a), 32'd0);
    check_output({tag, "_field_start"}, 32'(field_start_a), 32'd0);
    check_output({tag, "_field"}, 32'(field_a), 32'd0);
  endtask

  initial begin
    int sync_low;
    int burst_cnt;
    int ls_cnt;

    en = 1'b1;
    #1 rst = 1'b0;

    // Held in reset while en is high and tick toggles.
    for (int i = 0; i < 12; i++) clock_cycle(i % 4 == 3);
    check_reset_values("reset");

    // Release: first clk enters RUN without moving, first tick pulls sync low.
    rst = 1'b1;
    clock_cycle(1'b0);
    check_output("run_entry_sync_n", 32'(sync_n_a), 32'd1);
    apply_stimulus(1, 4);
    check_output("first_tick_sync_n", 32'(sync_n_a), 32'd0);
    check_output("first_tick_line_start", 32'(line_start_a), 32'd0);

    // Finish line 0; its wrap pulses line_start.
    apply_stimulus(793, 4);
    check_output("wrap0_line_start", 32'(line_start_a), 32'd1);

    // Measure line 1 in clk: sync width, burst width, pulse count and period.
    sync_low  = 0;
    burst_cnt = 0;
    ls_cnt    = 0;
    for (int i = 0; i < 3176; i++) begin
      if (i > 0) clock_cycle(i % 4 == 0);
      if (sync_n_a == 1'b0) sync_low++;
      if (burst_a == 1'b1) burst_cnt++;
      if (line_start_a == 1'b1) ls_cnt++;
    end
    check_output("line1_sync_low_clks", 32'(sync_low), 32'd236);
    check_output("line1_burst_clks", 32'(burst_cnt), 32'd124);
    check_output("line1_line_start_clks", 32'(ls_cnt), 32'd1);
    clock_cycle(1'b1);
    check_output("line2_line_start_period", 32'(line_start_a), 32'd1);

    // From here on, one tick per clk. Tick count is now 1588.
    apply_stimulus(2322, 1);
    check_output("vsync_l4_h734_sync_n", 32'(sync_n_a), 32'd0);
    check_output("vsync_l4_burst", 32'(burst_a), 32'd0);
    apply_stimulus(1, 1);
    check_output("vsync_l4_h735_sync_n", 32'(sync_n_a), 32'd1);

    apply_stimulus(12897, 1);
    check_output("l21_h134_active", 32'(active_a), 32'd1);
    check_output("l21_h134_blank", 32'(blank_a), 32'd0);
    check_output("l21_h134_x", 32'(x_a), 32'd0);
    check_output("l21_h134_y", 32'(y_a), 32'd0);
    apply_stimulus(639, 1);
    check_output("l21_h773_x", 32'(x_a), 32'd639);
    check_output("l21_h773_active", 32'(active_a), 32'd1);
    apply_stimulus(1, 1);
    check_output("l21_h774_active", 32'(active_a), 32'd0);
    check_output("l21_h774_x", 32'(x_a), 32'd0);

    apply_stimulus(22652, 1);
    check_output("l50_h400_x", 32'(x_a), 32'd266);
    check_output("l50_h400_y", 32'(y_a), 32'd29);

    // Enable drop mid-line, with a tick present that must be ignored.
    en = 1'b0;
    clock_cycle(1'b1);
    check_reset_values("en_drop");
    clock_cycle(1'b0);
    clock_cycle(1'b1);
    check_output("en_low_tick_ignored_sync_n", 32'(sync_n_a), 32'd1);

    // Restart from 0,0 with no pulses on the first line.
    en = 1'b1;
    clock_cycle(1'b0);
    check_output("restart_entry_sync_n", 32'(sync_n_a), 32'd1);
    apply_stimulus(1, 1);
    check_output("restart_sync_n", 32'(sync_n_a), 32'd0);
    check_output("restart_line_start", 32'(line_start_a), 32'd0);
    check_output("restart_field_start", 32'(field_start_a), 32'd0);
    apply_stimulus(793, 1);
    check_output("restart_wrap_line_start", 32'(line_start_a), 32'd1);
    check_output("restart_wrap_field_start", 32'(field_start_a), 32'd0);

    // dut_b has 12-line even fields: first field wrap at tick 9528.
    apply_stimulus(8734, 1);
    check_output("b_wrap1_line_start", 32'(line_start_b), 32'd1);
    check_output("b_wrap1_field_start", 32'(field_start_b), 32'd1);
    check_output("b_wrap1_field", 32'(field_b), INTERLACE ? 32'd1 : 32'd0);
    check_output("a_l12_field_start", 32'(field_start_a), 32'd0);
    apply_stimulus(12 * 794, 1);
    check_output("b_l24_line_start", 32'(line_start_b), 32'd1);
    check_output("b_l24_field_start", 32'(field_start_b), INTERLACE ? 32'd0 : 32'd1);
`ifdef NTSC_INTERLACE_EN
    apply_stimulus(794, 1);
    check_output("b_wrap2_field_start", 32'(field_start_b), 32'd1);
    check_output("b_wrap2_field", 32'(field_b), 32'd0);
`endif

    clock_cycle(1'b0);
    clock_cycle(1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
